// File: rtl/hilo_mul_ctrl.sv
// HI/LO sequencer for the multicycle datapath: issues low/high product requests to the
// signed multiplier, captures both words into HI/LO, and serves MTHI/MTLO. Build option: HILO_TIMEOUT_EN.
module hilo_mul_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi_we,
    input  logic        mtlo_we,
    input  logic [31:0] wdata,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mul_valid_in,
    output logic        mul_lo_hi,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_result,
    input  logic        mul_valid_out
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE_LO = 2'd1,
        ISSUE_HI = 2'd2,
        WAIT     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] mul_a_q, mul_a_d;
    logic [31:0] mul_b_q, mul_b_d;
    logic [1:0]  res_cnt_q, res_cnt_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mul_valid_in_q, mul_valid_in_d;
    logic        mul_lo_hi_q, mul_lo_hi_d;

`ifdef HILO_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               err_q, err_d;
`endif

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
        res_cnt_d = res_cnt_q;
        done_d    = 1'b0;
`ifdef HILO_TIMEOUT_EN
        timer_d   = timer_q;
        err_d     = err_q;
`endif

        case (state_q)
            IDLE: begin
                // start wins over a same-cycle MTHI/MTLO, which is then dropped
                if (start) begin
                    state_d   = ISSUE_LO;
                    mul_a_d   = a;
                    mul_b_d   = b;
                    res_cnt_d = 2'd0;
`ifdef HILO_TIMEOUT_EN
                    timer_d   = '0;
`endif
                end else begin
                    if (mthi_we) hi_d = wdata;
                    if (mtlo_we) lo_d = wdata;
                end
            end
            ISSUE_LO: state_d = ISSUE_HI;
            ISSUE_HI: state_d = WAIT;
            WAIT: begin
                if (res_cnt_q == 2'd2) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Capture is open in every busy state so a latency-1 multiplier can answer during ISSUE_HI
        if (state_q != IDLE && mul_valid_out) begin
            if (res_cnt_q == 2'd0) begin
                lo_d      = mul_result;
                res_cnt_d = 2'd1;
            end else if (res_cnt_q == 2'd1) begin
                hi_d      = mul_result;
                res_cnt_d = 2'd2;
            end
        end

`ifdef HILO_TIMEOUT_EN
        if (state_q != IDLE) begin
            timer_d = timer_q + TIMER_W'(1);
        end
        if (state_q == WAIT && res_cnt_q != 2'd2 &&
            timer_q == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
            state_d = IDLE;
            err_d   = 1'b1;
        end
`endif

        busy_d         = (state_d != IDLE);
        mul_valid_in_d = (state_d == ISSUE_LO) || (state_d == ISSUE_HI);
        mul_lo_hi_d    = (state_d == ISSUE_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            hi_q           <= '0;
            lo_q           <= '0;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            res_cnt_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            mul_valid_in_q <= 1'b0;
            mul_lo_hi_q    <= 1'b0;
`ifdef HILO_TIMEOUT_EN
            timer_q        <= '0;
            err_q          <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            res_cnt_q      <= res_cnt_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            mul_valid_in_q <= mul_valid_in_d;
            mul_lo_hi_q    <= mul_lo_hi_d;
`ifdef HILO_TIMEOUT_EN
            timer_q        <= timer_d;
            err_q          <= err_d;
`endif
        end
    end

    assign hi           = hi_q;
    assign lo           = lo_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign mul_valid_in = mul_valid_in_q;
    assign mul_lo_hi    = mul_lo_hi_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
`ifdef HILO_TIMEOUT_EN
    assign err          = err_q;
`else
    assign err          = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Bench for hilo_mul_ctrl: table of products through a variable-latency multiplier
// model, plus busy-ignore, MTHI/MTLO, back-to-back, reset and (HILO_TIMEOUT_EN) timeout sequences.
module tb_hilo_mul_ctrl;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        mthi_we = 1'b0;
    logic        mtlo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] hi, lo, mul_a, mul_b;
    logic        busy, done, err, mul_valid_in, mul_lo_hi;
    logic [31:0] mul_result = '0;
    logic        mul_valid_out = 1'b0;

    always #5 clk = ~clk;

    hilo_mul_ctrl #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .a             (a),
        .b             (b),
        .mthi_we       (mthi_we),
        .mtlo_we       (mtlo_we),
        .wdata         (wdata),
        .hi            (hi),
        .lo            (lo),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .mul_valid_in  (mul_valid_in),
        .mul_lo_hi     (mul_lo_hi),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_result    (mul_result),
        .mul_valid_out (mul_valid_out)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } resp_t;

    vec_t  vecs[7];
    exp_t  scoreboard[$];
    resp_t respQ[$];

    int vectorsApplied = 0;
    int miscompares = 0;
    int cycle = 0;
    int latency = 1;
    int strobeCount = 0;
    int doneCount = 0;
    int doneBase = 0;
    int busyCycles = 0;
    bit mute = 1'b0;

    always @(posedge clk) cycle++;

    // Multiplier model: answers each strobe 'latency' cycles later, in issue order
    always @(negedge clk) begin
        longint prod;
        resp_t  r;
        if (mul_valid_in === 1'b1) begin
            strobeCount++;
            prod = longint'($signed(mul_a)) * longint'($signed(mul_b));
            if (!mute) begin
                r.due  = cycle + latency;
                r.data = mul_lo_hi ? prod[63:32] : prod[31:0];
                respQ.push_back(r);
            end
        end
        mul_valid_out = 1'b0;
        mul_result    = '0;
        if (respQ.size() > 0 && respQ[0].due == cycle) begin
            r = respQ.pop_front();
            mul_valid_out = 1'b1;
            mul_result    = r.data;
        end
        if (busy === 1'b1) busyCycles++;
        if (done === 1'b1) doneCount++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectorsApplied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input int lat,
                                 input logic [31:0] eHi, input logic [31:0] eLo);
        exp_t e;
        e.hi = eHi;
        e.lo = eLo;
        scoreboard.push_back(e);
        latency     = lat;
        strobeCount = 0;
        busyCycles  = 0;
        doneBase    = doneCount;
        start = 1'b1;
        a     = ia;
        b     = ib;
        tick();
        start = 1'b0;
    endtask

    task automatic finishOp(input string tag);
        bit   seen;
        exp_t e;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (done === 1'b1) seen = 1'b1;
            else tick();
        end
        checkOutput({tag, " done seen"}, 64'(seen), 64'd1);
        if (scoreboard.size() == 0) begin
            checkOutput({tag, " scoreboard entry"}, 64'd0, 64'd1);
        end else begin
            e = scoreboard.pop_front();
            checkOutput({tag, " hi"}, 64'(hi), 64'(e.hi));
            checkOutput({tag, " lo"}, 64'(lo), 64'(e.lo));
        end
        checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
        checkOutput({tag, " err"}, 64'(err), 64'd0);
        checkOutput({tag, " strobes"}, 64'(strobeCount), 64'd2);
        checkOutput({tag, " busy cycles"}, 64'(busyCycles), 64'(3 + latency));
        checkOutput({tag, " done pulses"}, 64'(doneCount - doneBase), 64'd1);
    endtask

    initial begin
        vecs[0] = '{32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1};
        vecs[1] = '{32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 2};
        vecs[2] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 3};
        vecs[3] = '{32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 4};
        vecs[5] = '{32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 2};
        vecs[6] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1};

        tick();
        tick();
        checkOutput("reset hi", 64'(hi), 64'd0);
        checkOutput("reset lo", 64'(lo), 64'd0);
        checkOutput("reset busy/done/err", {61'd0, busy, done, err}, 64'd0);
        checkOutput("reset mul strobes", {62'd0, mul_valid_in, mul_lo_hi}, 64'd0);
        checkOutput("reset operands", {mul_a, mul_b}, 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].expHi, vecs[i].expLo);
            finishOp($sformatf("vec%0d", i));
            tick();
        end

        // Second start and MTHI/MTLO while busy must all be ignored
        applyStimulus(32'd5, 32'd5, 3, 32'd0, 32'd25);
        start   = 1'b1;
        a       = 32'd9;
        b       = 32'd9;
        mthi_we = 1'b1;
        wdata   = 32'h1234;
        tick();
        start   = 1'b0;
        mthi_we = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("busy lo captured", 64'(lo), 64'd25);
        checkOutput("busy operands held", {mul_a, mul_b}, {32'd5, 32'd5});
        mtlo_we = 1'b1;
        wdata   = 32'hBAD;
        tick();
        mtlo_we = 1'b0;
        finishOp("busy-ignore");
        for (int i = 0; i < 10; i++) tick();
        checkOutput("busy-ignore no extra done", 64'(doneCount - doneBase), 64'd1);
        checkOutput("busy-ignore no extra strobes", 64'(strobeCount), 64'd2);

        // MTHI/MTLO in IDLE, then dropped when paired with start
        mthi_we = 1'b1;
        wdata   = 32'hDEADBEEF;
        tick();
        mthi_we = 1'b0;
        checkOutput("mthi idle", 64'(hi), 64'hDEADBEEF);
        mtlo_we = 1'b1;
        wdata   = 32'h1;
        tick();
        mtlo_we = 1'b0;
        checkOutput("mtlo idle", {hi, lo}, {32'hDEADBEEF, 32'h1});
        mthi_we = 1'b1;
        mtlo_we = 1'b1;
        wdata   = 32'h55;
        tick();
        checkOutput("mthi+mtlo idle", {hi, lo}, {32'h55, 32'h55});
        wdata = 32'hCAFE;
        applyStimulus(32'd2, 32'd3, 2, 32'd0, 32'd6);
        mthi_we = 1'b0;
        mtlo_we = 1'b0;
        checkOutput("mt with start dropped", {hi, lo}, {32'h55, 32'h55});
        finishOp("mt-start");
        tick();

        // Back-to-back: next start in the cycle done is high
        applyStimulus(32'h0000FFFF, 32'h0000FFFF, 1, 32'h0, 32'hFFFE0001);
        finishOp("b2b-first");
        applyStimulus(32'hFFFFFFF9, 32'd6, 2, 32'hFFFFFFFF, 32'hFFFFFFD6);
        finishOp("b2b-second");
        tick();

        // Reset in WAIT after only the low word has arrived
        applyStimulus(32'd7, 32'd6, 4, 32'd0, 32'd42);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("pre-reset lo", 64'(lo), 64'd42);
        checkOutput("pre-reset busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #2;
        checkOutput("async reset hi/lo", {hi, lo}, 64'd0);
        checkOutput("async reset busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        void'(scoreboard.pop_front());
        for (int i = 0; i < 6; i++) tick();
        checkOutput("post-reset hi/lo", {hi, lo}, 64'd0);
        checkOutput("post-reset busy", 64'(busy), 64'd0);
        checkOutput("post-reset no done", 64'(doneCount - doneBase), 64'd0);

`ifdef HILO_TIMEOUT_EN
        mute = 1'b1;
        applyStimulus(32'd1, 32'd1, 1, 32'd0, 32'd1);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("timeout err before limit", {62'd0, err, busy}, {62'd0, 1'b0, 1'b1});
        tick();
        checkOutput("timeout err at limit", {61'd0, err, busy, done}, {61'd0, 1'b1, 1'b0, 1'b0});
        for (int i = 0; i < 4; i++) tick();
        checkOutput("timeout err sticky", 64'(err), 64'd1);
        checkOutput("timeout no done", 64'(doneCount - doneBase), 64'd0);
        void'(scoreboard.pop_front());
        mute = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
